// File: rtl/uvc_pkg.sv
// Shared types and constants for the UVC isochronous payload packer:
// FSM state encoding, payload header length and BFH bit positions.
package uvc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    EOFHDR0,
    EOFHDR1
  } state_t;

  localparam logic [7:0] UVC_HLE = 8'h02;

  localparam int BFH_FID = 0;
  localparam int BFH_EOF = 1;
  localparam int BFH_EOH = 7;

  // Second header byte (BFH): end-of-header always set, EOF and FID as given.
  function automatic logic [7:0] bfh_byte(input logic fid, input logic eof);
    logic [7:0] b;
    b          = '0;
    b[BFH_EOH] = 1'b1;
    b[BFH_EOF] = eof;
    b[BFH_FID] = fid;
    return b;
  endfunction

endpackage

// File: rtl/uvc_payload_packer.sv
// Packs a pixel byte stream into UVC isochronous payloads: a registered
// two-byte header followed by pixel bytes passed straight through.
module uvc_payload_packer
  import uvc_pkg::*;
#(
  parameter int MAX_PKT = 1024
) (
  input  logic        usb_clk_w,
  input  logic        rst_n,
  input  logic        stream_en_i,
  input  logic [7:0]  pix_data_i,
  input  logic        pix_valid_i,
  input  logic        pix_sof_i,
  input  logic        pix_eof_i,
  output logic        pix_ready_o,
  input  logic        ep_req_i,
  output logic [7:0]  ep_data_o,
  output logic        ep_valid_o,
  output logic        ep_last_o,
  input  logic        ep_ready_i,
  output logic        fid_o,
  output logic [15:0] frames_sent_o,
  output state_t      dbg_state_o
);

  // Handshake: a byte moves when valid && ready on a rising edge; a source
  // holding valid keeps data/sof/eof stable until that edge.

  // Index of the final data byte a packet may carry (header takes two bytes).
  localparam logic [9:0] LAST_IDX = 10'(MAX_PKT - 3);

  state_t     state;
  logic [7:0] hdr_byte;
  logic       hdr_valid;
  logic       eof_pend;
  logic       aligned;
  logic [9:0] cnt;

  logic data_last;
  logic data_xfer;
  logic hdr1_has_data;
  logic sof_seen;

  always_comb begin
    data_last     = pix_valid_i && (pix_eof_i || (cnt == LAST_IDX));
    data_xfer     = (state == DATA) && pix_valid_i && ep_ready_i;
    // Pre-sof bytes are not frame data, so they never open a DATA phase.
    hdr1_has_data = pix_valid_i && aligned;
    sof_seen      = pix_valid_i && pix_sof_i;
  end

  always_comb begin
    ep_data_o   = hdr_byte;
    ep_valid_o  = hdr_valid;
    ep_last_o   = 1'b0;
    pix_ready_o = 1'b0;
    case (state)
      DATA: begin
        ep_data_o   = pix_data_i;
        ep_valid_o  = pix_valid_i;
        ep_last_o   = data_last;
        pix_ready_o = ep_ready_i && !eof_pend;
      end
      HDR1:    ep_last_o = !hdr1_has_data;
      EOFHDR1: ep_last_o = 1'b1;
      // Discard bytes until a sof appears; the sof byte itself is held.
      IDLE:    pix_ready_o = stream_en_i && !aligned && !sof_seen;
      default: ;
    endcase
  end

  always_ff @(posedge usb_clk_w or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hdr_byte      <= 8'h00;
      hdr_valid     <= 1'b0;
      eof_pend      <= 1'b0;
      aligned       <= 1'b0;
      cnt           <= '0;
      fid_o         <= 1'b0;
      frames_sent_o <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (!stream_en_i) begin
            // Streaming stopped: the next enable starts from a fresh sof.
            aligned  <= 1'b0;
            eof_pend <= 1'b0;
          end else begin
            if (!aligned && sof_seen) aligned <= 1'b1;
            if (ep_req_i) begin
              state     <= eof_pend ? EOFHDR0 : HDR0;
              hdr_byte  <= UVC_HLE;
              hdr_valid <= 1'b1;
            end
          end
        end
        HDR0: begin
          if (ep_ready_i) begin
            state    <= HDR1;
            hdr_byte <= bfh_byte(fid_o, 1'b0);
          end
        end
        EOFHDR0: begin
          if (ep_ready_i) begin
            state    <= EOFHDR1;
            hdr_byte <= bfh_byte(fid_o, 1'b1);
          end
        end
        HDR1: begin
          cnt <= '0;
          if (ep_ready_i) begin
            hdr_valid <= 1'b0;
            state     <= hdr1_has_data ? DATA : IDLE;
          end
        end
        DATA: begin
          if (data_xfer) begin
            if (data_last) begin
              state <= IDLE;
              cnt   <= '0;
              if (pix_eof_i) eof_pend <= 1'b1;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        EOFHDR1: begin
          if (ep_ready_i) begin
            hdr_valid     <= 1'b0;
            eof_pend      <= 1'b0;
            fid_o         <= ~fid_o;
            frames_sent_o <= frames_sent_o + 16'd1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_uvc_payload_packer.sv
// Randomized scoreboard bench for uvc_payload_packer: a packet-level model
// predicts every endpoint byte, a monitor compares them as they transfer.
module tb_uvc_payload_packer;
  import uvc_pkg::*;

  localparam int MAX_PKT = 8;

  logic        usb_clk_w   = 1'b0;
  logic        rst_n       = 1'b0;
  logic        stream_en_i = 1'b0;
  logic [7:0]  pix_data_i  = 8'h00;
  logic        pix_valid_i = 1'b0;
  logic        pix_sof_i   = 1'b0;
  logic        pix_eof_i   = 1'b0;
  logic        pix_ready_o;
  logic        ep_req_i    = 1'b0;
  logic [7:0]  ep_data_o;
  logic        ep_valid_o;
  logic        ep_last_o;
  logic        ep_ready_i  = 1'b1;
  logic        fid_o;
  logic [15:0] frames_sent_o;
  state_t      dbg_state_o;

  uvc_payload_packer #(.MAX_PKT(MAX_PKT)) dut (
    .usb_clk_w    (usb_clk_w),
    .rst_n        (rst_n),
    .stream_en_i  (stream_en_i),
    .pix_data_i   (pix_data_i),
    .pix_valid_i  (pix_valid_i),
    .pix_sof_i    (pix_sof_i),
    .pix_eof_i    (pix_eof_i),
    .pix_ready_o  (pix_ready_o),
    .ep_req_i     (ep_req_i),
    .ep_data_o    (ep_data_o),
    .ep_valid_o   (ep_valid_o),
    .ep_last_o    (ep_last_o),
    .ep_ready_i   (ep_ready_i),
    .fid_o        (fid_o),
    .frames_sent_o(frames_sent_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 usb_clk_w = ~usb_clk_w;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  exp_q[$];   // {last, data}
  logic [9:0]  src_q[$];   // {sof, eof, data} bytes offered by the pixel source
  logic [9:0]  m_q[$];     // frame bytes the packer is expected to forward
  bit          m_fid      = 1'b0;
  logic [15:0] m_frames   = 16'h0000;
  bit          m_eof_pend = 1'b0;

  bit mon_en  = 1'b1;
  bit bp_mode = 1'b0;
  bit gap_en  = 1'b0;
  int gap_cnt = 0;
  bit took    = 1'b0;
  bit mid     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk_w);
    #2;
  endtask

  // ---------------- drivers ----------------
  always @(posedge usb_clk_w) begin
    #1;
    ep_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge usb_clk_w) begin
    took = rst_n && pix_valid_i && pix_ready_o;
    mid  = took && ep_valid_o && !ep_last_o && !pix_eof_i;
  end

  // Gaps are only inserted right after a non-final data byte, i.e. mid-packet.
  always @(posedge usb_clk_w) begin
    #1;
    if (took && src_q.size() > 0) void'(src_q.pop_front());
    if (mid && gap_en) gap_cnt = $urandom_range(0, 2);
    if (gap_cnt > 0) begin
      gap_cnt--;
      pix_valid_i = 1'b0;
    end else if (src_q.size() > 0) begin
      {pix_sof_i, pix_eof_i, pix_data_i} = src_q[0];
      pix_valid_i = 1'b1;
    end else begin
      pix_valid_i = 1'b0;
      pix_sof_i   = 1'b0;
      pix_eof_i   = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge usb_clk_w) begin
    logic [8:0] e;
    if (rst_n && mon_en && ep_valid_o && ep_ready_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ep_byte: got last=%0b data=%0h expected none", ep_last_o, ep_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({ep_last_o, ep_data_o} !== e) begin
          n_fail++;
          $display("FAIL ep_byte: got last=%0b data=%0h expected last=%0b data=%0h",
                   ep_last_o, ep_data_o, e[8], e[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_garbage(input logic [7:0] b);
    src_q.push_back({2'b00, b});
  endtask

  task automatic load_frame(input int len, input bit rnd, input logic [7:0] base);
    logic [9:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == 0), (i == len - 1), rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(i))};
      src_q.push_back(e);
      m_q.push_back(e);
    end
  endtask

  // Predict one payload, request it, and wait for the monitor to drain it.
  task automatic send_req(input int drop_after);
    logic [9:0] e;
    logic [7:0] fb;
    int k, n, budget;
    bit last;
    exp_q.push_back({1'b0, 8'h02});
    if (m_eof_pend) begin
      fb = 8'h82 | {7'd0, m_fid};
      exp_q.push_back({1'b1, fb});
      m_fid      = !m_fid;
      m_frames   = m_frames + 16'd1;
      m_eof_pend = 1'b0;
    end else if (m_q.size() == 0) begin
      fb = 8'h80 | {7'd0, m_fid};
      exp_q.push_back({1'b1, fb});
    end else begin
      fb = 8'h80 | {7'd0, m_fid};
      exp_q.push_back({1'b0, fb});
      k = 0;
      last = 1'b0;
      while (!last && m_q.size() > 0) begin
        e = m_q.pop_front();
        k++;
        last = e[8] || (k == MAX_PKT - 2);
        exp_q.push_back({last, e[7:0]});
        if (e[8]) m_eof_pend = 1'b1;
      end
    end
    n = exp_q.size();
    tick();
    ep_req_i = 1'b1;
    tick();
    ep_req_i = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 300) begin
      if (drop_after > 0 && (n - exp_q.size()) >= 2 + drop_after) stream_en_i = 1'b0;
      tick();
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL packet_timeout: got %0d bytes expected %0d", n - exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) tick();
    check("fid", {31'd0, fid_o}, {31'd0, m_fid});
    check("frames_sent", {16'd0, frames_sent_o}, {16'd0, m_frames});
  endtask

  task automatic run_frame();
    int guard;
    guard = 0;
    while ((m_q.size() > 0 || m_eof_pend) && guard < 64) begin
      send_req(0);
      guard++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge usb_clk_w);
    @(negedge usb_clk_w);
    check("rst_ep_valid", {31'd0, ep_valid_o}, 32'd0);
    check("rst_ep_last", {31'd0, ep_last_o}, 32'd0);
    check("rst_ep_data", {24'd0, ep_data_o}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready_o}, 32'd0);
    check("rst_fid", {31'd0, fid_o}, 32'd0);
    check("rst_frames", {16'd0, frames_sent_o}, 32'd0);
    check("rst_state", {29'd0, dbg_state_o}, {29'd0, IDLE});
    tick();
    rst_n = 1'b1;
    tick();
    check("disabled_pix_ready", {31'd0, pix_ready_o}, 32'd0);

    // Alignment: leading non-sof bytes are dropped, first frame starts at 0x30.
    stream_en_i = 1'b1;
    load_garbage(8'h11);
    load_garbage(8'h22);
    load_frame(3, 1'b0, 8'h30);
    repeat (6) tick();
    run_frame();

    // 14-byte frame split across three payloads, then the EOF header.
    load_frame(14, 1'b0, 8'h00);
    repeat (2) tick();
    run_frame();

    // Nothing pending: header-only payload.
    send_req(0);

    // Random frames with endpoint backpressure and source gaps.
    bp_mode = 1'b1;
    gap_en  = 1'b1;
    for (int f = 0; f < 8; f++) begin
      load_frame($urandom_range(1, 20), 1'b1, 8'h00);
      repeat (2) tick();
      run_frame();
    end

    // Streaming disabled after the third data byte: payload still completes.
    load_frame(10, 1'b1, 8'h00);
    repeat (2) tick();
    send_req(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge usb_clk_w);
      check("stream_off_pix_ready", {31'd0, pix_ready_o}, 32'd0);
    end
    check("stream_off_state", {29'd0, dbg_state_o}, {29'd0, IDLE});
    m_eof_pend = 1'b0;
    while (m_q.size() > 0 && !m_q[0][9]) void'(m_q.pop_front());
    tick();
    stream_en_i = 1'b1;
    load_frame(5, 1'b1, 8'h00);
    repeat (12) tick();
    run_frame();

    // Frame counter wrap.
    force dut.frames_sent_o = 16'hFFFF;
    @(negedge usb_clk_w);
    release dut.frames_sent_o;
    tick();
    m_frames = 16'hFFFF;
    check("frames_forced", {16'd0, frames_sent_o}, 32'h0000FFFF);
    load_frame(2, 1'b1, 8'h00);
    repeat (2) tick();
    run_frame();
    check("frames_wrapped", {16'd0, frames_sent_o}, 32'd0);

    // Reset in the middle of a payload abandons it.
    bp_mode = 1'b0;
    gap_en  = 1'b0;
    load_frame(10, 1'b1, 8'h00);
    repeat (2) tick();
    mon_en = 1'b0;
    ep_req_i = 1'b1;
    tick();
    ep_req_i = 1'b0;
    repeat (4) tick();
    check("pre_reset_in_data", {29'd0, dbg_state_o}, {29'd0, DATA});
    rst_n = 1'b0;
    src_q.delete();
    m_q.delete();
    exp_q.delete();
    m_fid = 1'b0;
    m_frames = 16'h0000;
    m_eof_pend = 1'b0;
    @(negedge usb_clk_w);
    check("midrst_ep_valid", {31'd0, ep_valid_o}, 32'd0);
    check("midrst_fid", {31'd0, fid_o}, 32'd0);
    check("midrst_frames", {16'd0, frames_sent_o}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge usb_clk_w);
      check("post_rst_ep_valid", {31'd0, ep_valid_o}, 32'd0);
    end
    tick();
    mon_en = 1'b1;
    load_garbage(8'h55);
    load_garbage(8'h66);
    load_frame(3, 1'b1, 8'h00);
    repeat (10) tick();
    run_frame();

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
